maq_t: RTL and testbench



---
 rtl/maq_pkg.sv | 25 ++
 rtl/maq_bcd_dec.sv | 35 +++
 rtl/maq_t.sv | 131 +++++++++++++
 tb/tb_maq_t.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/maq_pkg.sv
// Shared types and constants for the MM:SS BCD countdown timer.
package maq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    DONE
  } maq_t_state_e;

  localparam int unsigned BCD_LSD_MAX = 9;
  localparam int unsigned BCD_MSD_MAX = 5;

  typedef struct packed {
    logic [2:0] min_msd;
    logic [3:0] min_lsd;
    logic [2:0] sec_msd;
    logic [3:0] sec_lsd;
  } maq_mmss_t;

  function automatic logic mmss_is_zero(maq_mmss_t t);
    return t == '0;
  endfunction

endpackage

// File: rtl/maq_bcd_dec.sv
// Combinational decrement of one 00-59 BCD digit pair, gated by borrow_i.
module maq_bcd_dec
  import maq_pkg::*;
#(
  parameter int unsigned MSD_MAX = BCD_MSD_MAX,
  parameter int unsigned LSD_MAX = BCD_LSD_MAX
) (
  input  logic [3:0] lsd_i,
  input  logic [2:0] msd_i,
  input  logic       borrow_i,
  output logic [3:0] lsd_o,
  output logic [2:0] msd_o,
  output logic       borrow_o
);

  always_comb begin
    lsd_o    = lsd_i;
    msd_o    = msd_i;
    borrow_o = 1'b0;
    if (borrow_i) begin
      if (lsd_i != 4'd0) begin
        lsd_o = lsd_i - 4'd1;
      end else begin
        lsd_o = 4'(LSD_MAX);
        if (msd_i != 3'd0) begin
          msd_o = msd_i - 3'd1;
        end else begin
          msd_o    = 3'(MSD_MAX);
          borrow_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/maq_t.sv
// MM:SS BCD countdown timer: host load/start/pause/clear, 1 Hz decrement,
// one-cycle expiry pulse and load-reject pulse.
module maq_t
  import maq_pkg::*;
#(
  parameter int unsigned MSD_MAX = BCD_MSD_MAX,
  parameter int unsigned LSD_MAX = BCD_LSD_MAX
) (
  input  logic       maqt_clock,
  input  logic       maqt_reset,
  input  logic       maqt_enable,
  input  logic       maqt_load,
  input  logic       maqt_start,
  input  logic       maqt_pause,
  input  logic       maqt_clear,
  input  logic [3:0] maqt_ld_sec_lsd,
  input  logic [2:0] maqt_ld_sec_msd,
  input  logic [3:0] maqt_ld_min_lsd,
  input  logic [2:0] maqt_ld_min_msd,
  output logic [3:0] maqt_sec_lsd,
  output logic [2:0] maqt_sec_msd,
  output logic [3:0] maqt_min_lsd,
  output logic [2:0] maqt_min_msd,
  output logic       maqt_running,
  output logic       maqt_expired,
  output logic       maqt_done,
  output logic       maqt_load_err
);

  maq_t_state_e state_q, state_d;
  maq_mmss_t    count_q, count_d, count_dec, load_val;
  logic         done_q, done_d;
  logic         load_err_q, load_err_d;
  logic         running_q, expired_q;
  logic         load_valid;

  logic [3:0] dec_sec_lsd, dec_min_lsd;
  logic [2:0] dec_sec_msd, dec_min_msd;
  logic       sec_borrow;
  // Minutes never borrow out: a zero count is never decremented.
  logic       min_borrow_unused;

  assign load_val = {maqt_ld_min_msd, maqt_ld_min_lsd, maqt_ld_sec_msd, maqt_ld_sec_lsd};

  assign load_valid = (maqt_ld_sec_lsd <= 4'(LSD_MAX)) && (maqt_ld_min_lsd <= 4'(LSD_MAX)) &&
                      (maqt_ld_sec_msd <= 3'(MSD_MAX)) && (maqt_ld_min_msd <= 3'(MSD_MAX));

  maq_bcd_dec #(
    .MSD_MAX (MSD_MAX),
    .LSD_MAX (LSD_MAX)
  ) u_sec_dec (
    .lsd_i    (count_q.sec_lsd),
    .msd_i    (count_q.sec_msd),
    .borrow_i (1'b1),
    .lsd_o    (dec_sec_lsd),
    .msd_o    (dec_sec_msd),
    .borrow_o (sec_borrow)
  );

  maq_bcd_dec #(
    .MSD_MAX (MSD_MAX),
    .LSD_MAX (LSD_MAX)
  ) u_min_dec (
    .lsd_i    (count_q.min_lsd),
    .msd_i    (count_q.min_msd),
    .borrow_i (sec_borrow),
    .lsd_o    (dec_min_lsd),
    .msd_o    (dec_min_msd),
    .borrow_o (min_borrow_unused)
  );

  assign count_dec = {dec_min_msd, dec_min_lsd, dec_sec_msd, dec_sec_lsd};

  // Requests that are ignored in the current state fall through to lower priorities.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    done_d     = 1'b0;
    load_err_d = 1'b0;
    if (maqt_clear) begin
      count_d = '0;
      state_d = IDLE;
    end else if (maqt_load && (state_q != RUN)) begin
      if (load_valid) begin
        count_d = load_val;
        state_d = IDLE;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (maqt_pause && (state_q == RUN)) begin
      state_d = PAUSE;
    end else if (maqt_start && ((state_q == IDLE) || (state_q == PAUSE)) &&
                 !mmss_is_zero(count_q)) begin
      state_d = RUN;
    end else if (maqt_enable && (state_q == RUN)) begin
      count_d = count_dec;
      if (mmss_is_zero(count_dec)) begin
        state_d = DONE;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge maqt_clock) begin
    if (maqt_reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      done_q     <= 1'b0;
      load_err_q <= 1'b0;
      running_q  <= 1'b0;
      expired_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      done_q     <= done_d;
      load_err_q <= load_err_d;
      running_q  <= (state_d == RUN);
      expired_q  <= (state_d == DONE);
    end
  end

  assign maqt_sec_lsd  = count_q.sec_lsd;
  assign maqt_sec_msd  = count_q.sec_msd;
  assign maqt_min_lsd  = count_q.min_lsd;
  assign maqt_min_msd  = count_q.min_msd;
  assign maqt_running  = running_q;
  assign maqt_expired  = expired_q;
  assign maqt_done     = done_q;
  assign maqt_load_err = load_err_q;

endmodule

// File: tb/tb_maq_t.sv
// Bench for maq_t: directed steps then random traffic, checked every cycle against
// a seconds-count reference model.
module tb_maq_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0, en = 1'b0, ld = 1'b0, st = 1'b0, ps = 1'b0, clr = 1'b0;
  logic [3:0] ld_sl = '0, ld_ml = '0;
  logic [2:0] ld_sm = '0, ld_mm = '0;
  logic [3:0] sec_lsd, min_lsd;
  logic [2:0] sec_msd, min_msd;
  logic       running, expired, done, load_err;

  int n_tests = 0;
  int n_fail  = 0;

  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
  int m_secs = 0;
  int m_st   = M_IDLE;
  bit m_done = 1'b0, m_err = 1'b0;

  maq_t dut (
    .maqt_clock      (clk),
    .maqt_reset      (rst),
    .maqt_enable     (en),
    .maqt_load       (ld),
    .maqt_start      (st),
    .maqt_pause      (ps),
    .maqt_clear      (clr),
    .maqt_ld_sec_lsd (ld_sl),
    .maqt_ld_sec_msd (ld_sm),
    .maqt_ld_min_lsd (ld_ml),
    .maqt_ld_min_msd (ld_mm),
    .maqt_sec_lsd    (sec_lsd),
    .maqt_sec_msd    (sec_msd),
    .maqt_min_lsd    (min_lsd),
    .maqt_min_msd    (min_msd),
    .maqt_running    (running),
    .maqt_expired    (expired),
    .maqt_done       (done),
    .maqt_load_err   (load_err)
  );

  always #10 clk = ~clk;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model works in total seconds; digits are derived only for comparison.
  task automatic model_step();
    bit valid;
    valid = (ld_sl <= 9) && (ld_ml <= 9) && (ld_sm <= 5) && (ld_mm <= 5);
    m_done = 1'b0;
    m_err  = 1'b0;
    if (rst) begin
      m_secs = 0;
      m_st   = M_IDLE;
    end else if (clr) begin
      m_secs = 0;
      m_st   = M_IDLE;
    end else if (ld && m_st != M_RUN) begin
      if (valid) begin
        m_secs = (10 * int'(ld_mm) + int'(ld_ml)) * 60 + 10 * int'(ld_sm) + int'(ld_sl);
        m_st   = M_IDLE;
      end else begin
        m_err = 1'b1;
      end
    end else if (ps && m_st == M_RUN) begin
      m_st = M_PAUSE;
    end else if (st && (m_st == M_IDLE || m_st == M_PAUSE) && m_secs != 0) begin
      m_st = M_RUN;
    end else if (en && m_st == M_RUN) begin
      m_secs = m_secs - 1;
      if (m_secs == 0) begin
        m_st   = M_DONE;
        m_done = 1'b1;
      end
    end
  endtask

  function automatic logic [17:0] exp_vec();
    int ss, mm;
    ss = m_secs % 60;
    mm = m_secs / 60;
    return {4'(ss % 10), 3'(ss / 10), 4'(mm % 10), 3'(mm / 10),
            m_st == M_RUN, m_st == M_DONE, m_done, m_err};
  endfunction

  function automatic logic [17:0] obs_vec();
    return {sec_lsd, sec_msd, min_lsd, min_msd, running, expired, done, load_err};
  endfunction

  task automatic drive(bit r, bit e, bit l, bit s, bit p, bit c);
    rst = r; en = e; ld = l; st = s; ps = p; clr = c;
    @(posedge clk);
    model_step();
    #1;
    check("model", 32'(obs_vec()), 32'(exp_vec()));
    {rst, en, ld, st, ps, clr} = '0;
  endtask

  task automatic set_ld(int mm, int ml, int sm, int sl);
    ld_mm = mm[2:0]; ld_ml = ml[3:0]; ld_sm = sm[2:0]; ld_sl = sl[3:0];
  endtask

  task automatic check_time(string tag, int mmss);
    logic [13:0] exp;
    exp = {3'(mmss / 1000), 4'((mmss / 100) % 10), 3'((mmss / 10) % 10), 4'(mmss % 10)};
    check(tag, 32'({min_msd, min_lsd, sec_msd, sec_lsd}), 32'(exp));
  endtask

  initial begin
    // Reset
    drive(1, 0, 0, 0, 0, 0);
    check_time("reset_digits", 0);
    check("reset_flags", 32'({running, expired, done, load_err}), 32'(0));

    // 00:03 countdown to expiry
    set_ld(0, 0, 0, 3);
    drive(0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    check("start_running", 32'(running), 32'(1));
    drive(0, 1, 0, 0, 0, 0); check_time("cd_0002", 2);
    drive(0, 1, 0, 0, 0, 0); check_time("cd_0001", 1);
    check("no_early_done", 32'(done), 32'(0));
    drive(0, 1, 0, 0, 0, 0); check_time("cd_0000", 0);
    check("done_pulse", 32'({done, expired, running}), 32'(3'b110));
    drive(0, 0, 0, 0, 0, 0);
    check("done_one_cycle", 32'({done, expired}), 32'(2'b01));

    // Borrow chains
    drive(0, 0, 0, 0, 0, 1);
    set_ld(1, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    drive(0, 1, 0, 0, 0, 0); check_time("borrow_0959", 959);
    drive(0, 0, 0, 0, 0, 1);
    set_ld(0, 1, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    drive(0, 1, 0, 0, 0, 0); check_time("borrow_0059", 59);

    // Pause discards a coincident tick and freezes
    drive(0, 0, 0, 0, 0, 1);
    set_ld(0, 0, 0, 5);
    drive(0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    drive(0, 1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 1, 0); check_time("pause_tick", 3);
    check("paused_not_running", 32'(running), 32'(0));
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, 0, 0, 0);
      check_time("pause_hold", 3);
    end
    drive(0, 1, 0, 1, 0, 0); check_time("start_tick_dropped", 3);
    drive(0, 1, 0, 0, 0, 0); check_time("resume", 2);

    // Invalid loads and load while running
    drive(0, 0, 0, 0, 1, 0);
    set_ld(0, 0, 0, 10);
    drive(0, 0, 1, 0, 0, 0);
    check("err_sec_lsd", 32'(load_err), 32'(1)); check_time("err_keep", 2);
    drive(0, 0, 0, 0, 0, 0);
    check("err_one_cycle", 32'(load_err), 32'(0));
    set_ld(6, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    check("err_min_msd", 32'(load_err), 32'(1)); check_time("err_keep2", 2);
    drive(0, 0, 0, 1, 0, 0);
    set_ld(0, 1, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    check("run_load_ignored", 32'({load_err, running}), 32'(2'b01));
    check_time("run_load_keep", 2);

    // Start at zero, clear mid-run
    drive(0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 1, 0, 0);
    check("start_zero", 32'(running), 32'(0));
    set_ld(1, 2, 3, 4);
    drive(0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 1);
    check_time("clear_digits", 0);
    check("clear_flags", 32'({running, expired, done}), 32'(0));

    // Reset coincident with final tick
    set_ld(0, 0, 0, 1);
    drive(0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    drive(1, 1, 0, 0, 0, 0);
    check("rst_flags", 32'({running, expired, done, load_err}), 32'(0));
    drive(0, 0, 0, 0, 0, 0);
    check("rst_no_done", 32'(done), 32'(0));

    // Load and clear together
    set_ld(0, 0, 0, 7);
    drive(0, 0, 1, 0, 0, 1);
    check_time("clear_over_load", 0);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) set_ld($urandom_range(0, 6), $urandom_range(0, 10),
                                            $urandom_range(0, 6), $urandom_range(0, 10));
      else set_ld(0, 0, $urandom_range(0, 1), $urandom_range(0, 10));
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 19) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 14) == 0, $urandom_range(0, 59) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
